minrv32_fetch: RTL and testbench

Instruction fetch and prefetch stage that sits directly upstream of the minrv32 core's insn/insn_valid input.
- Issues word reads on a dedicated instruction bus that uses the same valid/ready handshake as the core's data bus.
- Buffers returned words in a small FIFO and presents the head to the core.
- Holds the presented insn stable until the core retires it.
- Restarts at a new address when the core redirects on a taken branch, jump or trap.

---
 rtl/minrv32_fetch_if.sv | 35 +++
 rtl/minrv32_fetch.sv | 146 ++++++++++++++
 tb/tb_minrv32_fetch.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minrv32_fetch_if.sv
// Fetch-stage bundle: imem request/response bus plus the core-side instruction port.
// master = fetch stage; slave = instruction memory and core.
interface minrv32_fetch_if;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        insn_done;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;

  modport master (
    output imem_valid, imem_addr, insn, insn_pc, insn_valid, fetch_misalign,
    input  imem_ready, imem_rdata, insn_done, redirect, redirect_pc
  );
  modport slave (
    input  imem_valid, imem_addr, insn, insn_pc, insn_valid, fetch_misalign,
    output imem_ready, imem_rdata, insn_done, redirect, redirect_pc
  );
`else
  modport master (
    output imem_valid, imem_addr, insn, insn_pc, insn_valid,
    input  imem_ready, imem_rdata, insn_done, redirect, redirect_pc
  );
  modport slave (
    input  imem_valid, imem_addr, insn, insn_pc, insn_valid,
    output imem_ready, imem_rdata, insn_done, redirect, redirect_pc
  );
`endif
endinterface

// File: rtl/minrv32_fetch.sv
// minrv32 prefetch: one outstanding imem read into a DEPTH-entry FIFO; first request 1 cycle after reset, stalls when no room.
// MINRV32_FETCH_ALIGN_CHECK_EN: a misaligned redirect raises fetch_misalign and halts fetch until an aligned redirect.
module minrv32_fetch #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0001_0000,
  parameter int          DEPTH          = 2
) (
  input logic             clk,
  input logic             resetn,
  minrv32_fetch_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] dat_q [DEPTH];
  logic [31:0] dat_d [DEPTH];
  logic [31:0] pc_q  [DEPTH];
  logic [31:0] pc_d  [DEPTH];
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        cnt_q, cnt_d;
  logic        imem_valid_q, imem_valid_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
`endif

  logic        accept;
  logic        outstanding;
  logic        push;
  logic        pop;
  logic        issue;
  logic        halt_d;
  logic [31:0] redir_al;
  logic [31:0] base_pc;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    accept      = imem_valid_q & bus.imem_ready;
    outstanding = imem_valid_q & ~bus.imem_ready;
    // A redirect outranks both the returning word and the core's retire.
    push        = accept & ~discard_q & ~bus.redirect;
    pop         = (cnt_q != '0) & bus.insn_done & ~bus.redirect;
    redir_al    = bus.redirect_pc & 32'hFFFF_FFFC;

    dat_d    = dat_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        dat_d[wr_ptr_q] = bus.imem_rdata;
        pc_d[wr_ptr_q]  = imem_addr_q;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + cnt_t'(1);
        2'b01:   cnt_d = cnt_q - cnt_t'(1);
        default: cnt_d = cnt_q;
      endcase
    end

`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
    misalign_d = misalign_q;
    if (bus.redirect) begin
      misalign_d = (bus.redirect_pc[1:0] != 2'b00);
    end
    halt_d = misalign_d;
`else
    halt_d = 1'b0;
`endif

    base_pc   = bus.redirect ? redir_al : fetch_pc_q;
    // An in-flight request is left on the bus untouched; only its data gets dropped.
    discard_d = bus.redirect ? outstanding : (discard_q & outstanding);

    issue = ~outstanding & ~halt_d & (int'(cnt_d) < DEPTH);

    imem_valid_d = outstanding | issue;
    imem_addr_d  = imem_addr_q;
    fetch_pc_d   = base_pc;
    if (issue) begin
      imem_addr_d = base_pc;
      fetch_pc_d  = base_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      imem_valid_q <= 1'b0;
      imem_addr_q  <= PROGADDR_RESET;
      fetch_pc_q   <= PROGADDR_RESET;
      discard_q    <= 1'b0;
`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      dat_q        <= dat_d;
      pc_q         <= pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      imem_valid_q <= imem_valid_d;
      imem_addr_q  <= imem_addr_d;
      fetch_pc_q   <= fetch_pc_d;
      discard_q    <= discard_d;
`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign bus.imem_valid = imem_valid_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.insn       = dat_q[rd_ptr_q];
  assign bus.insn_pc    = pc_q[rd_ptr_q];
  assign bus.insn_valid = (cnt_q != '0);
`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
  assign bus.fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_minrv32_fetch.sv
// Bench for minrv32_fetch: modelled instruction memory with programmable wait states,
// retire scoreboard of expected {pc, word} pairs pushed as insn_done is driven.
module tb_minrv32_fetch;

  logic clk;
  logic resetn;

  minrv32_fetch_if bus ();

  minrv32_fetch #(
    .PROGADDR_RESET(32'h0001_0000),
    .DEPTH         (2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          resp_en = 0;
  int          wait_cycles = 0;
  int          wcnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // Instruction memory model: ready after wait_cycles low cycles of a pending request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resp_en && bus.imem_valid) begin
        if (wcnt >= wait_cycles) begin
          bus.imem_ready = 1'b1;
          wcnt = 0;
        end else begin
          bus.imem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        bus.imem_ready = 1'b0;
        if (!bus.imem_valid) wcnt = 0;
      end
      bus.imem_rdata = mem_word(bus.imem_addr);
    end
  end

  // Retire scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (resetn && bus.insn_valid && bus.insn_done && !bus.redirect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected: insn_pc=%h retired, no retirement expected", bus.insn_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.insn_pc !== e || bus.insn !== mem_word(e)) begin
            errors++;
            $display("FAIL retire: insn_pc=%h insn=%h, expected pc=%h insn=%h",
                     bus.insn_pc, bus.insn, e, mem_word(e));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset(input int wc);
    step();
    resetn = 1'b0;
    bus.insn_done = 1'b0;
    bus.redirect = 1'b0;
    step();
    step();
    wait_cycles = wc;
    resp_en = 1'b1;
    resetn = 1'b1;
  endtask

  // Wait at negedges until the FIFO is full and no request is pending.
  task automatic wait_full(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      sample();
      if (!bus.imem_valid && bus.insn_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    sample();
    sample();
    checks++;
    if (bus.imem_valid !== 1'b0) begin errors++; $display("FAIL reset_imem_valid: got %b, expected 0", bus.imem_valid); end
    checks++;
    if (bus.imem_addr !== 32'h0001_0000) begin errors++; $display("FAIL reset_imem_addr: got %h, expected 00010000", bus.imem_addr); end
    checks++;
    if (bus.insn_valid !== 1'b0) begin errors++; $display("FAIL reset_insn_valid: got %b, expected 0", bus.insn_valid); end
    checks++;
    if (bus.insn !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h, expected 0", bus.insn); end
    checks++;
    if (bus.insn_pc !== 32'h0) begin errors++; $display("FAIL reset_insn_pc: got %h, expected 0", bus.insn_pc); end
`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
    checks++;
    if (bus.fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b, expected 0", bus.fetch_misalign); end
`endif
    resp_en = 1'b1;
    wait_cycles = 0;
  endtask

  task automatic test_fill();
    step();
    resetn = 1'b1;
    sample();
    checks++;
    if (bus.imem_valid !== 1'b0) begin errors++; $display("FAIL fill_no_early_req: imem_valid=%b, expected 0 before first edge", bus.imem_valid); end
    sample();
    checks++;
    if (bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h0001_0000) begin
      errors++; $display("FAIL fill_first_req: valid=%b addr=%h, expected 1 00010000", bus.imem_valid, bus.imem_addr);
    end
    sample();
    checks++;
    if (bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h0001_0004 || bus.insn_valid !== 1'b1 || bus.insn_pc !== 32'h0001_0000) begin
      errors++; $display("FAIL fill_second_req: valid=%b addr=%h insn_valid=%b insn_pc=%h, expected 1 00010004 1 00010000",
                         bus.imem_valid, bus.imem_addr, bus.insn_valid, bus.insn_pc);
    end
    sample();
    checks++;
    if (bus.imem_valid !== 1'b0) begin errors++; $display("FAIL fill_full_stall: imem_valid=%b, expected 0", bus.imem_valid); end
    for (int i = 0; i < 10; i++) begin
      sample();
      checks++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== 32'h0001_0000 || bus.insn !== mem_word(32'h0001_0000) || bus.imem_valid !== 1'b0) begin
        errors++; $display("FAIL fill_hold: cycle %0d insn_valid=%b insn_pc=%h insn=%h imem_valid=%b, expected 1 00010000 %h 0",
                           i, bus.insn_valid, bus.insn_pc, bus.insn, bus.imem_valid, mem_word(32'h0001_0000));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    exp_pc = 32'h0001_0000;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.insn_done = 1'b1;
      checks++;
      if (bus.insn_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_bubble: cycle %0d insn_valid=%b, expected 1", i, bus.insn_valid);
      end else begin
        exp_q.push_back(exp_pc);
        exp_pc += 32'd4;
      end
    end
    step();
    bus.insn_done = 1'b0;
    sample();
    checks++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== 32'h0001_0020) begin
      errors++; $display("FAIL b2b_next_head: insn_valid=%b insn_pc=%h, expected 1 00010020", bus.insn_valid, bus.insn_pc);
    end
  endtask

  task automatic test_wait_states();
    logic        pv, pr, pend;
    logic [31:0] pa, exp_addr, ret_pc, pend_pc;
    bit          ok;
    do_reset(3);
    pv = 1'b0; pr = 1'b0; pa = '0; pend = 1'b0; pend_pc = '0;
    exp_addr = 32'h0001_0000;
    ret_pc   = 32'h0001_0000;
    for (int i = 0; i < 30; i++) begin
      step();
      bus.insn_done = 1'b0;
      if ((i % 6) == 5 && bus.insn_valid) begin
        bus.insn_done = 1'b1;
        exp_q.push_back(ret_pc);
        ret_pc += 32'd4;
      end
      sample();
      if (pv && !pr) begin
        checks++;
        if (bus.imem_valid !== 1'b1 || bus.imem_addr !== pa) begin
          errors++; $display("FAIL wait_hold: valid=%b addr=%h, expected 1 %h", bus.imem_valid, bus.imem_addr, pa);
        end
      end
      if (pend) begin
        checks++;
        if (bus.insn_valid !== 1'b1 || bus.insn_pc !== pend_pc) begin
          errors++; $display("FAIL wait_insn_after_ready: insn_valid=%b insn_pc=%h, expected 1 %h", bus.insn_valid, bus.insn_pc, pend_pc);
        end
        pend = 1'b0;
      end
      if (bus.imem_valid && bus.imem_ready) begin
        checks++;
        if (bus.imem_addr !== exp_addr) begin
          errors++; $display("FAIL wait_addr_seq: accepted addr=%h, expected %h", bus.imem_addr, exp_addr);
        end
        exp_addr += 32'd4;
        if (!bus.insn_valid) begin
          pend = 1'b1;
          pend_pc = bus.imem_addr;
        end
      end
      pv = bus.imem_valid; pr = bus.imem_ready; pa = bus.imem_addr;
    end
    step();
    bus.insn_done = 1'b0;
    if (bus.insn_valid) begin
      bus.insn_done = 1'b1;
      exp_q.push_back(ret_pc);
    end
    step();
    bus.insn_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      sample();
      if (bus.imem_valid && !bus.imem_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wait_find_pending: no pending request seen, expected one within 20 cycles");
    end else begin
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.imem_valid !== 1'b0 || bus.insn_valid !== 1'b0) begin
        errors++; $display("FAIL async_reset_drop: imem_valid=%b insn_valid=%b, expected 0 0", bus.imem_valid, bus.insn_valid);
      end
    end
  endtask

  task automatic test_redirect_pending();
    bit ok;
    do_reset(0);
    wait_full(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rdp_fill: FIFO not full in time, expected full"); end
    resp_en = 1'b0;
    step();
    if (bus.insn_valid) begin
      bus.insn_done = 1'b1;
      exp_q.push_back(32'h0001_0000);
    end
    step();
    bus.insn_done = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0002_0040;
    sample();
    checks++;
    if (bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h0001_0008) begin
      errors++; $display("FAIL rdp_pending: valid=%b addr=%h, expected 1 00010008", bus.imem_valid, bus.imem_addr);
    end
    step();
    bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h0001_0008 || bus.insn_valid !== 1'b0) begin
        errors++; $display("FAIL rdp_hold: valid=%b addr=%h insn_valid=%b, expected 1 00010008 0",
                           bus.imem_valid, bus.imem_addr, bus.insn_valid);
      end
    end
    resp_en = 1'b1;
    sample();
    sample();
    checks++;
    if (bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h0002_0040 || bus.insn_valid !== 1'b0) begin
      errors++; $display("FAIL rdp_new_req: valid=%b addr=%h insn_valid=%b, expected 1 00020040 0",
                         bus.imem_valid, bus.imem_addr, bus.insn_valid);
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (bus.insn_valid) ok = 1'b1;
    end
    checks++;
    if (!ok || bus.insn_pc !== 32'h0002_0040) begin
      errors++; $display("FAIL rdp_head: insn_valid=%b insn_pc=%h, expected 1 00020040", bus.insn_valid, bus.insn_pc);
    end
    if (ok) begin
      bus.insn_done = 1'b1;
      exp_q.push_back(32'h0002_0040);
    end
    step();
    bus.insn_done = 1'b0;
  endtask

  task automatic test_redirect_done_full();
    bit ok;
    do_reset(0);
    wait_full(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rdf_fill: FIFO not full in time, expected full"); end
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0003_0000;
    bus.insn_done = 1'b1;
    step();
    bus.redirect = 1'b0;
    bus.insn_done = 1'b0;
    sample();
    checks++;
    if (bus.insn_valid !== 1'b0 || bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h0003_0000) begin
      errors++; $display("FAIL rdf_flush: insn_valid=%b imem_valid=%b addr=%h, expected 0 1 00030000",
                         bus.insn_valid, bus.imem_valid, bus.imem_addr);
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (bus.insn_valid) ok = 1'b1;
    end
    checks++;
    if (!ok || bus.insn_pc !== 32'h0003_0000) begin
      errors++; $display("FAIL rdf_head: insn_valid=%b insn_pc=%h, expected 1 00030000", bus.insn_valid, bus.insn_pc);
    end
    if (ok) begin
      bus.insn_done = 1'b1;
      exp_q.push_back(32'h0003_0000);
    end
    step();
    bus.insn_done = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    int          n;
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFA;
    step();
    bus.redirect = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.insn_done = bus.insn_valid;
      if (bus.insn_valid) begin
        exp_q.push_back(exp_pc);
        exp_pc += 32'd4;
        n++;
      end
    end
    step();
    bus.insn_done = 1'b0;
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL wrap_count: retired %0d across the wrap, expected 8", n);
    end
  endtask

`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
  task automatic test_misalign();
    bit ok;
    do_reset(0);
    wait_full(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mis_fill: FIFO not full in time, expected full"); end
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0002_0042;
    step();
    bus.redirect = 1'b0;
    sample();
    checks++;
    if (bus.fetch_misalign !== 1'b1 || bus.insn_valid !== 1'b0) begin
      errors++; $display("FAIL mis_set: misalign=%b insn_valid=%b, expected 1 0", bus.fetch_misalign, bus.insn_valid);
    end
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if (bus.imem_valid !== 1'b0) begin
        errors++; $display("FAIL mis_halt: cycle %0d imem_valid=%b, expected 0", i, bus.imem_valid);
      end
    end
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0002_0044;
    step();
    bus.redirect = 1'b0;
    sample();
    checks++;
    if (bus.fetch_misalign !== 1'b0 || bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h0002_0044) begin
      errors++; $display("FAIL mis_clear: misalign=%b valid=%b addr=%h, expected 0 1 00020044",
                         bus.fetch_misalign, bus.imem_valid, bus.imem_addr);
    end
  endtask
`endif

  initial begin
    resetn          = 1'b1;
    bus.imem_ready  = 1'b0;
    bus.imem_rdata  = '0;
    bus.insn_done   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    #1;
    resetn = 1'b0;

    test_reset();
    test_fill();
    test_back_to_back();
    test_wait_states();
    test_redirect_pending();
    test_redirect_done_full();
    test_wrap();
`ifdef MINRV32_FETCH_ALIGN_CHECK_EN
    test_misalign();
`endif

    sample();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d expected retirements left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
